// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable-format UART receiver with majority-vote sampling,
// error-tagged output FIFO and overrun/break/idle/end-of-packet reporting.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 15_000_000,
    parameter int BAUD       = 38400,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 rx_idle,
    output logic                 rx_endofpacket
);
    localparam int DIV_RAW  = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV      = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DIV_W    = DIV > 1 ? $clog2(DIV) : 1;
    localparam int PW       = $clog2(OVERSAMPLE);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int FW       = DATA_BITS + 2;
    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IW       = $clog2(IDLE_MAX + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BRK_WAIT} stateType;

    logic [DIV_W-1:0]     divCnt;
    logic                 tick;
    logic                 sync1, sync2, maj, fell;
    logic [2:0]           hist;
    stateType             state, stateNext;
    logic [PW-1:0]        phase;
    logic [3:0]           bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parBit, stop0, ferrAcc;
    logic                 midBit, startCheck, lastData, lastStop;
    logic                 sampleData, sampleStop, done, isBreak, wordPerr, wordFerr;
    logic [FW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr, rdPtr;
    logic [CW-1:0]        count;
    logic                 full, push, pop, wordOk;
    logic [IW-1:0]        idleCnt;
    logic                 idlePrev;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) divCnt <= '0;
        else divCnt <= tick ? '0 : divCnt + DIV_W'(1);
    assign tick = divCnt == DIV_W'(DIV - 1);

    // Synchronizer presets to mark so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= '1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            if (tick) hist <= {hist[1:0], sync2};
        end

    assign maj  = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign fell = hist[0] & ~sync2;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else state <= stateNext;

    always_comb begin
        stateNext = state;
        if (tick)
            case (state)
                ST_IDLE:     stateNext = fell ? ST_START : ST_IDLE;
                ST_START:    if (startCheck) stateNext = maj ? ST_IDLE : ST_DATA;
                ST_DATA:     if (midBit && lastData) stateNext = PARITY != 0 ? ST_PARITY : ST_STOP;
                ST_PARITY:   if (midBit) stateNext = ST_STOP;
                ST_STOP:     if (midBit && lastStop) stateNext = isBreak ? ST_BRK_WAIT : ST_IDLE;
                ST_BRK_WAIT: if (maj) stateNext = ST_IDLE;
                default:     stateNext = ST_IDLE;
            endcase
    end

    always_comb begin
        midBit     = phase == PW'(OVERSAMPLE - 1);
        startCheck = phase == PW'(OVERSAMPLE / 2 - 1);
        lastData   = bitCnt == 4'(DATA_BITS - 1);
        lastStop   = bitCnt == 4'(STOP_BITS - 1);
        sampleData = tick && midBit && state == ST_DATA;
        sampleStop = tick && midBit && state == ST_STOP;
        done       = sampleStop && lastStop;
        isBreak    = shiftReg == '0 && (PARITY == 0 || !parBit) && !(bitCnt == 4'd0 ? maj : stop0);
        wordPerr   = PARITY == 0 ? 1'b0 : (^shiftReg) ^ parBit ^ (PARITY == 1);
        wordFerr   = ferrAcc | ~maj;
    end

    // Phase restarts on every state change so each bit is sampled OVERSAMPLE ticks after the last
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase    <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            parBit   <= 1'b0;
            stop0    <= 1'b1;
            ferrAcc  <= 1'b0;
        end else if (tick) begin
            phase   <= (stateNext != state || midBit || state == ST_IDLE || state == ST_BRK_WAIT) ? '0 : phase + PW'(1);
            bitCnt  <= stateNext != state ? 4'd0 : (sampleData || sampleStop) ? bitCnt + 4'd1 : bitCnt;
            ferrAcc <= sampleStop ? ferrAcc | ~maj : state == ST_STOP ? ferrAcc : 1'b0;
            if (sampleData) shiftReg <= {maj, shiftReg[DATA_BITS-1:1]};
            if (state == ST_PARITY && midBit) parBit <= maj;
            if (sampleStop && bitCnt == 4'd0) stop0 <= maj;
        end

    always_comb begin
        full   = count == CW'(FIFO_DEPTH);
        pop    = rx_valid && rx_ready;
        wordOk = done && !isBreak;
        push   = wordOk && (!full || pop);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            if (push) begin
                mem[wrPtr] <= {wordPerr, wordFerr, shiftReg};
                wrPtr      <= wrPtr + AW'(1);
            end
            if (pop) rdPtr <= rdPtr + AW'(1);
            count     <= count + CW'(push) - CW'(pop);
            overrun   <= wordOk && full && !pop;
            break_det <= done && isBreak;
        end

    assign rx_valid                     = count != '0;
    assign {rx_perr, rx_ferr, rx_data} = mem[rdPtr];

    // Reset value is saturated so no end-of-packet pulse follows reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idleCnt  <= IW'(IDLE_MAX);
            idlePrev <= 1'b1;
        end else begin
            idleCnt  <= (state != ST_IDLE || !sync2) ? '0 : (tick && !rx_idle) ? idleCnt + IW'(1) : idleCnt;
            idlePrev <= rx_idle;
        end

    assign rx_idle        = idleCnt == IW'(IDLE_MAX);
    assign rx_endofpacket = rx_idle && !idlePrev;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg in 8N1, 8E1 and 7O2 formats at 16 clocks per bit.
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxdA, rxdB, rxdC;
    logic       readyA, readyB, readyC;
    logic [7:0] aData, bData;
    logic [6:0] cData;
    logic       aPerr, aFerr, aValid, aOvr, aBrk, aIdle, aEop;
    logic       bPerr, bFerr, bValid, bOvr, bBrk, bIdle, bEop;
    logic       cPerr, cFerr, cValid, cOvr, cBrk, cIdle, cEop;
    int         checks = 0, errors = 0;
    int         ovrCnt = 0, brkCnt = 0, eopCnt = 0;
    int         lat, base;
    logic [8:0] w;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .IDLE_BITS(16)) uA (
        .clk(clk), .rst_n(rst_n), .rxd(rxdA), .rx_data(aData), .rx_perr(aPerr), .rx_ferr(aFerr),
        .rx_valid(aValid), .rx_ready(readyA), .overrun(aOvr), .break_det(aBrk), .rx_idle(aIdle),
        .rx_endofpacket(aEop));

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .IDLE_BITS(16)) uB (
        .clk(clk), .rst_n(rst_n), .rxd(rxdB), .rx_data(bData), .rx_perr(bPerr), .rx_ferr(bFerr),
        .rx_valid(bValid), .rx_ready(readyB), .overrun(bOvr), .break_det(bBrk), .rx_idle(bIdle),
        .rx_endofpacket(bEop));

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .IDLE_BITS(16)) uC (
        .clk(clk), .rst_n(rst_n), .rxd(rxdC), .rx_data(cData), .rx_perr(cPerr), .rx_ferr(cFerr),
        .rx_valid(cValid), .rx_ready(readyC), .overrun(cOvr), .break_det(cBrk), .rx_idle(cIdle),
        .rx_endofpacket(cEop));

    always @(negedge clk) begin
        if (aOvr) ovrCnt++;
        if (aBrk) brkCnt++;
        if (aEop) eopCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bitOut(input int sel, input logic v, input int n);
        if (sel == 0) rxdA = v;
        else if (sel == 1) rxdB = v;
        else rxdC = v;
        repeat (n) @(negedge clk);
    endtask

    // par < 0 means no parity bit; first stop bit is always mark
    task automatic sendTail(input int sel, input logic [8:0] d, input int nb, input int par,
                            input int nstop, input logic s2);
        for (int i = 0; i < nb; i++) bitOut(sel, d[i], 16);
        if (par >= 0) bitOut(sel, par[0], 16);
        bitOut(sel, 1'b1, 16);
        if (nstop == 2) bitOut(sel, s2, 16);
        bitOut(sel, 1'b1, 0);
    endtask

    task automatic sendFrame(input int sel, input logic [8:0] d, input int nb, input int par,
                             input int nstop, input logic s2);
        bitOut(sel, 1'b0, 16);
        sendTail(sel, d, nb, par, nstop, s2);
    endtask

    task automatic pop(input int sel);
        if (sel == 0) readyA = 1'b1;
        else if (sel == 1) readyB = 1'b1;
        else readyC = 1'b1;
        @(negedge clk);
        readyA = 1'b0;
        readyB = 1'b0;
        readyC = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rxdA = 1'b1; rxdB = 1'b1; rxdC = 1'b1;
        readyA = 1'b0; readyB = 1'b0; readyC = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(aValid), 32'd0);
        check("rst_data", 32'(aData), 32'd0);
        check("rst_idle", 32'(aIdle), 32'd1);
        check("rst_flags", 32'({aPerr, aFerr, aOvr, aBrk, aEop}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_eop", 32'(eopCnt), 32'd0);

        // 8N1 0xA5 with valid latency measured from the start of the stop bit
        w = 9'h0A5;
        bitOut(0, 1'b0, 16);
        for (int i = 0; i < 8; i++) bitOut(0, w[i], 16);
        rxdA = 1'b1;
        lat = 0;
        while (!aValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("a5_latency", 32'(lat), 32'd11);
        check("a5_data", 32'(aData), 32'h0A5);
        check("a5_perr", 32'(aPerr), 32'd0);
        check("a5_ferr", 32'(aFerr), 32'd0);
        repeat (5) @(negedge clk);
        pop(0);
        check("a5_popped", 32'(aValid), 32'd0);

        // 8E1: wrong parity on 0x07, then correct parity on 0x03
        sendFrame(1, 9'h007, 8, 0, 1, 1'b1);
        check("e07_valid", 32'(bValid), 32'd1);
        check("e07_data", 32'(bData), 32'h07);
        check("e07_perr", 32'(bPerr), 32'd1);
        check("e07_ferr", 32'(bFerr), 32'd0);
        pop(1);
        sendFrame(1, 9'h003, 8, 0, 1, 1'b1);
        check("e03_data", 32'(bData), 32'h03);
        check("e03_perr", 32'(bPerr), 32'd0);

        // 7O2: 0x55 with good odd parity, second stop bit low
        sendFrame(2, 9'h055, 7, 1, 2, 1'b0);
        check("o55_data", 32'(cData), 32'h55);
        check("o55_ferr", 32'(cFerr), 32'd1);
        check("o55_perr", 32'(cPerr), 32'd0);

        // Overrun: five frames into a four-entry FIFO
        base = ovrCnt;
        for (int k = 1; k <= 5; k++) sendFrame(0, 9'(k), 8, -1, 1, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_pulses", 32'(ovrCnt - base), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("ovr_pop_data", 32'(aData), 32'(k));
            pop(0);
        end
        check("ovr_empty", 32'(aValid), 32'd0);

        // Short low glitch on idle line is a false start
        base = brkCnt;
        bitOut(0, 1'b0, 5);
        bitOut(0, 1'b1, 40);
        check("glitch_no_word", 32'(aValid), 32'd0);
        check("glitch_no_brk", 32'(brkCnt - base), 32'd0);

        // 0xFF with a 3-clock dip in bit 3 overlapping one of its three samples
        bitOut(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) bitOut(0, 1'b1, 16);
        bitOut(0, 1'b1, 7);
        bitOut(0, 1'b0, 3);
        bitOut(0, 1'b1, 6);
        for (int i = 4; i < 8; i++) bitOut(0, 1'b1, 16);
        bitOut(0, 1'b1, 16);
        check("mask_data", 32'(aData), 32'hFF);
        check("mask_ferr", 32'(aFerr), 32'd0);
        pop(0);

        // Break: 12 bit times low
        base = brkCnt;
        bitOut(0, 1'b0, 192);
        bitOut(0, 1'b1, 48);
        check("brk_pulses", 32'(brkCnt - base), 32'd1);
        check("brk_no_word", 32'(aValid), 32'd0);
        sendFrame(0, 9'h03C, 8, -1, 1, 1'b1);
        check("post_brk_data", 32'(aData), 32'h3C);
        check("post_brk_flags", 32'({aPerr, aFerr}), 32'd0);
        pop(0);

        // Idle / end-of-packet around two back-to-back frames
        repeat (300) @(negedge clk);
        check("idle_before", 32'(aIdle), 32'd1);
        base = eopCnt;
        bitOut(0, 1'b0, 4);
        check("idle_drop", 32'(aIdle), 32'd0);
        bitOut(0, 1'b0, 12);
        sendTail(0, 9'h011, 8, -1, 1, 1'b1);
        sendFrame(0, 9'h022, 8, -1, 1, 1'b1);
        check("eop_not_yet", 32'(aEop), 32'd0);
        lat = 0;
        while (!aEop && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("eop_delay", 32'(lat), 32'd251);
        repeat (50) @(negedge clk);
        check("eop_once", 32'(eopCnt - base), 32'd1);
        check("idle_after", 32'(aIdle), 32'd1);
        check("b2b_first", 32'(aData), 32'h11);
        pop(0);
        check("b2b_second", 32'(aData), 32'h22);
        pop(0);

        // Async reset in the middle of a frame with a word already queued
        sendFrame(0, 9'h077, 8, -1, 1, 1'b1);
        check("pre_rst_valid", 32'(aValid), 32'd1);
        bitOut(0, 1'b0, 16);
        bitOut(0, 1'b1, 16);
        bitOut(0, 1'b0, 5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(aValid), 32'd0);
        check("midrst_idle", 32'(aIdle), 32'd1);
        check("midrst_data", 32'(aData), 32'd0);
        rxdA = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = eopCnt;
        repeat (300) @(negedge clk);
        check("postrst_valid", 32'(aValid), 32'd0);
        check("postrst_idle", 32'(aIdle), 32'd1);
        check("postrst_no_eop", 32'(eopCnt - base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
